bob_addr_mw: RTL
================

Name: bob_addr_mw

Overview:
- Multi-way successor to the single-entry buffer-of-branches (BOB) address tracker.
- Manages a circular buffer of DEPTH entries, which need not be a power of two.
- Per cycle: allocates up to NEW_MAX consecutive entries at the tail and retires up to RET_MAX entries at the head.
- Sits between the rename/allocate stage and the BOB RAM. Supplies write addresses, the next-cycle read address, occupancy and stall.

Parameters:
- DEPTH, 48, number of buffer entries (2..2^AW).
- AW, 6, address width.
- NEW_MAX, 2, max allocations per cycle (1..4).
- RET_MAX, 2, max retirements per cycle (1..4).
- AF_THRESH, 40, almost-full threshold; used only with BOB_ADDR_MW_AF_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- except  in  1  flush; discards all occupied entries.
- new_cnt  in  3  entries requested this cycle (0..NEW_MAX).
- stall  in  1  external stall; blocks allocation.
- doStall  out  1  combinational; request does not fit.
- new_addr  out  AW  registered tail; first allocated entry is new_addr, then +1, +2 (mod DEPTH).
- occ  out  AW+1  registered occupancy, 0..DEPTH.
- hasRetire  out  1  occ!=0.
- ret_cnt  in  3  entries retired this cycle (0..RET_MAX).
- retire_addr  out  AW  combinational head for next cycle (drives RAM read_addr).
- retire_addr_q  out  AW  registered current head.
- almost_full  out  1  only with BOB_ADDR_MW_AF_EN.

Behaviour:
- Reset (rst=1 at posedge):
  - tail=0, head=0, occ=0; almost_full=0.
  - retire_addr=0 combinationally while rst is high.
- All pointer arithmetic is modulo DEPTH. Wrap is an explicit compare against DEPTH-1-k, not bit truncation.
- Effective retire: ret_eff = min(ret_cnt, occ).
  - An over-request is clamped, never underflows.
  - Clamping is flagged by a simulation-only assertion.
- doStall = (occ + new_cnt > DEPTH).
  - Uses the registered occ. Same-cycle retirements do not free space for same-cycle allocation (no bypass).
- grant = new_cnt!=0 && !stall && !doStall && !except.
- Allocation is all-or-nothing. When grant=0, tail does not move and no entry is allocated.
- Normal posedge (rst=0, except=0):
  - tail <= tail + (grant ? new_cnt : 0).
  - head <= head + ret_eff.
  - occ <= occ + (grant ? new_cnt : 0) - ret_eff.
- Simultaneous full allocate and full retire is legal. occ is unchanged and both pointers advance.
- except=1 posedge (rst has priority over except):
  - head <= tail, occ <= 0.
  - tail unchanged; the new_cnt and ret_cnt inputs are ignored.
- retire_addr (combinational):
  - rst: 0.
  - else except: tail.
  - else: head + ret_eff mod DEPTH.
- Latency:
  - An entry allocated at edge N is counted in occ after edge N.
  - It is retirable (hasRetire) from cycle N+1.
- new_cnt > NEW_MAX or ret_cnt > RET_MAX is illegal; assertion only, outputs undefined.

Optional Feature:
- Macro: BOB_ADDR_MW_AF_EN.
- Defined:
  - almost_full port exists, registered.
  - almost_full <= (next occ >= AF_THRESH). Cleared by rst and by except.
  - Lets the front end throttle one cycle before doStall.
- Undefined:
  - Port absent, AF_THRESH unused.
  - No extra flops; all other behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles with new_cnt=2 -> new_addr=0, occ=0, hasRetire=0, retire_addr=0, doStall=0.
- Fill: new_cnt=2 for 24 cycles, ret_cnt=0 -> new_addr 0,2,...,46,0; occ=48. Then new_cnt=1 -> doStall=1, new_addr stays 0.
- Wrap: preset tail=47, occ=0; new_cnt=2 -> entries 47,0 allocated, new_addr=1. Then ret_cnt=2 -> retire_addr 47 then 1, occ back to 0.
- Full plus retire: occ=48, new_cnt=2, ret_cnt=2 -> doStall=1, no allocation, occ=46. Next cycle the same inputs -> grant, occ stays 46.
- Except: occ=10, tail=10, head=0, except=1 with new_cnt=2, ret_cnt=1 -> retire_addr=10 that cycle; after edge head=10, occ=0, new_addr=10.
- Clamp/AF: occ=1, ret_cnt=2 -> occ=0, head+1. With BOB_ADDR_MW_AF_EN, filling to occ=40 -> almost_full=1 the cycle occ=40 appears.

Source files
------------

// File: rtl/bob_addr_mw.sv
// rtl/bob_addr_mw.sv - multi-way BOB address tracker (optional almost_full via BOB_ADDR_MW_AF_EN)
module bob_addr_mw #(
    parameter int DEPTH     = 48,
    parameter int AW        = 6,
    parameter int NEW_MAX   = 2,
    parameter int RET_MAX   = 2,
    parameter int AF_THRESH = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          except,
    input  logic [2:0]    new_cnt,
    input  logic          stall,
    output logic          doStall,
    output logic [AW-1:0] new_addr,
    output logic [AW:0]   occ,
    output logic          hasRetire,
    input  logic [2:0]    ret_cnt,
    output logic [AW-1:0] retire_addr,
    output logic [AW-1:0] retire_addr_q
`ifdef BOB_ADDR_MW_AF_EN
    ,
    output logic          almost_full
`endif
);

    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_head;
    logic [AW:0]   r_occ;

    logic [2:0]    w_ret_eff;
    logic [2:0]    w_new_eff;
    logic          w_grant;
    logic          w_do_stall;
    logic [AW-1:0] w_tail_nxt;
    logic [AW-1:0] w_head_nxt;
    logic [AW:0]   w_occ_nxt;

    // Advance a pointer by k entries around a ring of DEPTH slots. DEPTH need
    // not be a power of two, so the wrap is an explicit compare, not truncation.
    function automatic logic [AW-1:0] f_adv(input logic [AW-1:0] p, input logic [2:0] k);
        if (int'(p) > DEPTH - 1 - int'(k))
            f_adv = AW'(int'(p) + int'(k) - DEPTH);
        else
            f_adv = AW'(int'(p) + int'(k));
    endfunction

    // Grant/stall decision, retire clamping and next-state pointer arithmetic.
    always_comb begin
        w_ret_eff  = (int'(ret_cnt) > int'(r_occ)) ? 3'(r_occ) : ret_cnt;
        // Registered occupancy only: same-cycle retirements never make room.
        w_do_stall = (int'(r_occ) + int'(new_cnt)) > DEPTH;
        w_grant    = (new_cnt != 3'd0) && !stall && !w_do_stall && !except;
        w_new_eff  = w_grant ? new_cnt : 3'd0;
        w_tail_nxt = f_adv(r_tail, w_new_eff);
        w_head_nxt = f_adv(r_head, w_ret_eff);
        w_occ_nxt  = (AW+1)'(int'(r_occ) + int'(w_new_eff) - int'(w_ret_eff));
    end

    // Next-cycle RAM read address: the head as it will be after this edge.
    always_comb begin
        if (rst)
            retire_addr = '0;
        else if (except)
            retire_addr = r_tail;
        else
            retire_addr = w_head_nxt;
    end

    // Pointer and occupancy state; a flush empties the buffer by moving head to tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail <= '0;
            r_head <= '0;
            r_occ  <= '0;
        end else if (except) begin
            r_head <= r_tail;
            r_occ  <= '0;
        end else begin
            r_tail <= w_tail_nxt;
            r_head <= w_head_nxt;
            r_occ  <= w_occ_nxt;
        end
    end

`ifdef BOB_ADDR_MW_AF_EN
    logic r_af;

    // Early warning one cycle ahead of doStall, based on the occupancy being loaded.
    always_ff @(posedge clk) begin
        if (rst || except)
            r_af <= 1'b0;
        else
            r_af <= int'(w_occ_nxt) >= AF_THRESH;
    end

    assign almost_full = r_af;
`endif

    assign doStall       = w_do_stall;
    assign new_addr      = r_tail;
    assign occ           = r_occ;
    assign hasRetire     = (r_occ != '0);
    assign retire_addr_q = r_head;

    a_param_ok: assert property (@(posedge clk)
        DEPTH >= 2 && DEPTH <= (1 << AW) && AF_THRESH >= 0 && AF_THRESH <= DEPTH);
    a_new_legal: assert property (@(posedge clk) disable iff (rst)
        int'(new_cnt) <= NEW_MAX);
    a_ret_legal: assert property (@(posedge clk) disable iff (rst)
        int'(ret_cnt) <= RET_MAX);
    // Over-requested retirement is legal but worth seeing in coverage reports.
    c_ret_clamped: cover property (@(posedge clk) disable iff (rst)
        !except && int'(ret_cnt) > int'(r_occ));

endmodule
